// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute/writeback stage: widths, opcodes and FSM states.
package alu_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_AW_DEF = 5;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Ops that produce a write in the cycle after acceptance (everything but MUL and reserved).
    function automatic logic is_single(input logic [3:0] op);
        return (op <= OP_SLTU) || (op == OP_PASSB);
    endfunction

endpackage

// File: rtl/alu_writeback_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock, DATA_W steps per product.
module mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] addend;

    assign addend = mplier[0] ? mcand : '0;

    // done flags the edge carrying the last iteration; product already includes that step.
    assign done    = (cnt == CNT_W'(1));
    assign product = acc + addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CNT_W'(DATA_W);
        end else if (cnt != '0) begin
            acc    <= acc + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage feeding the register file write port; single-cycle ALU plus
// an iterative multiplier that stalls upstream through in_ready.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    state_t            state, state_next;
    logic              accept;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [REG_AW-1:0] mul_rd;
    logic [DATA_W-1:0] alu_res;
    logic [SH_W-1:0]   shamt;

    assign accept = in_valid & in_ready;
    assign shamt  = b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:   alu_res = a + b;
            OP_SUB:   alu_res = a - b;
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_SLL:   alu_res = a << shamt;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = DATA_W'($signed(a) >>> shamt);
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_PASSB: alu_res = b;
            default:  alu_res = '0;
        endcase
    end

    mul_iter #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && (op == OP_MUL)) state_next = MUL;
            MUL:     if (mul_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && (state == IDLE);
        busy      = (state == MUL);
        mul_start = accept && (op == OP_MUL);
    end

    // Writeback registers: a single-cycle accept and a MUL completion never share an edge,
    // since accepts only happen in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            mul_rd  <= '0;
        end else begin
            wb_en <= 1'b0;
            if (accept && is_single(op)) begin
                wb_en   <= 1'b1;
                wb_addr <= rd;
                wb_data <= alu_res;
            end else if ((state == MUL) && mul_done) begin
                wb_en   <= 1'b1;
                wb_addr <= mul_rd;
                wb_data <= mul_product;
            end
            if (mul_start) begin
                mul_rd <= rd;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_writeback_stage #(
        .DATA_W(16),
        .REG_AW(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rd       (rd),
        .a        (a),
        .b        (b),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .busy     (busy)
    );

    function automatic logic [15:0] ref_result(input int unsigned o, input logic [15:0] x, input logic [15:0] y);
        int          sx = int'($signed(x));
        int          sy = int'($signed(y));
        int unsigned ux = int'(x);
        int unsigned uy = int'(y);
        int unsigned sh = uy % 16;
        longint      prod;
        case (o)
            0:  return 16'(ux + uy);
            1:  return 16'(ux - uy);
            2:  return x & y;
            3:  return x | y;
            4:  return x ^ y;
            5:  return 16'(ux << sh);
            6:  return 16'(ux >> sh);
            7:  return 16'(sx >>> sh);
            8:  return (sx < sy) ? 16'd1 : 16'd0;
            9:  return (ux < uy) ? 16'd1 : 16'd0;
            10: begin
                prod = longint'(ux) * longint'(uy);
                return 16'(prod);
            end
            11: return y;
            default: return 16'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [4:0] r, input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1;
        op = o;
        rd = r;
        a = x;
        b = y;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0; rd = '0; a = '0; b = '0;
        step(); step();
        total++; if (wb_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL reset_hold ctrl: wb_en=%b busy=%b in_ready=%b want 0/0/0", wb_en, busy, in_ready); else passed++;
        total++; if (wb_addr !== 5'd0 || wb_data !== 16'd0) $display("FAIL reset_hold data: addr=%0d data=%h want 0/0000", wb_addr, wb_data); else passed++;
        rst = 1'b0;
        step();
        total++; if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b want 1", in_ready); else passed++;
        drive(4'd0, 5'd9, 16'h1234, 16'h1111);
        step();
        in_valid = 1'b0;
        total++; if (wb_en !== 1'b1 || wb_data !== 16'h2345) $display("FAIL reset_pre_write wb_en=%b data=%h want 1/2345", wb_en, wb_data); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (wb_en !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_async wb_en=%b addr=%0d data=%h busy=%b in_ready=%b want all 0", wb_en, wb_addr, wb_data, busy, in_ready);
        else passed++;
        step();
        rst = 1'b0;
        step();
        total++; if (in_ready !== 1'b1 || wb_en !== 1'b0) $display("FAIL reset_release2 in_ready=%b wb_en=%b want 1/0", in_ready, wb_en); else passed++;
    endtask

    task automatic test_add();
        drive(4'd0, 5'd3, 16'hFFFF, 16'h0002);
        step();
        in_valid = 1'b0;
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd3 || wb_data !== 16'h0001)
            $display("FAIL add wb_en=%b addr=%0d data=%h want 1/3/0001", wb_en, wb_addr, wb_data);
        else passed++;
        step();
        total++; if (wb_en !== 1'b0 || wb_addr !== 5'd3 || wb_data !== 16'h0001)
            $display("FAIL add_hold wb_en=%b addr=%0d data=%h want 0/3/0001", wb_en, wb_addr, wb_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        drive(4'd1, 5'd1, 16'd5, 16'd7);
        step();
        drive(4'd7, 5'd2, 16'h8000, 16'd4);
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd1 || wb_data !== 16'hFFFE)
            $display("FAIL b2b_sub wb_en=%b addr=%0d data=%h want 1/1/FFFE", wb_en, wb_addr, wb_data);
        else passed++;
        step();
        drive(4'd8, 5'd4, 16'hFFFF, 16'd1);
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd2 || wb_data !== 16'hF800)
            $display("FAIL b2b_sra wb_en=%b addr=%0d data=%h want 1/2/F800", wb_en, wb_addr, wb_data);
        else passed++;
        step();
        in_valid = 1'b0;
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd4 || wb_data !== 16'h0001)
            $display("FAIL b2b_slt wb_en=%b addr=%0d data=%h want 1/4/0001", wb_en, wb_addr, wb_data);
        else passed++;
        step();
        total++; if (wb_en !== 1'b0) $display("FAIL b2b_end wb_en=%b want 0", wb_en); else passed++;
    endtask

    task automatic test_mul();
        int bad = 0;
        drive(4'd10, 5'd7, 16'h0123, 16'h0045);
        step();
        for (int i = 0; i < 16; i++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1 || wb_en !== 1'b0) bad++;
            drive(4'($urandom_range(0, 11)), 5'($urandom), 16'($urandom), 16'($urandom));
            step();
        end
        total++; if (bad != 0) $display("FAIL mul_stall bad_cycles=%0d want 0", bad); else passed++;
        drive(4'd0, 5'd8, 16'd10, 16'd20);
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 16'h4E6F)
            $display("FAIL mul_result wb_en=%b addr=%0d data=%h want 1/7/4E6F", wb_en, wb_addr, wb_data);
        else passed++;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mul_ready in_ready=%b busy=%b want 1/0", in_ready, busy); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd8 || wb_data !== 16'd30)
            $display("FAIL mul_follow_add wb_en=%b addr=%0d data=%h want 1/8/001e", wb_en, wb_addr, wb_data);
        else passed++;
        step();
    endtask

    task automatic test_mul_reset();
        int writes = 0;
        drive(4'd10, 5'd6, 16'h00FF, 16'h00FF);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || in_ready !== 1'b0 || wb_en !== 1'b0)
            $display("FAIL mulrst_async busy=%b in_ready=%b wb_en=%b want 0/0/0", busy, in_ready, wb_en);
        else passed++;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wb_en !== 1'b0) writes++;
            step();
        end
        total++; if (writes != 0) $display("FAIL mulrst_no_write writes=%0d want 0", writes); else passed++;
        drive(4'd0, 5'd5, 16'd2, 16'd2);
        step();
        in_valid = 1'b0;
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 16'h0004)
            $display("FAIL mulrst_add wb_en=%b addr=%0d data=%h want 1/5/0004", wb_en, wb_addr, wb_data);
        else passed++;
        step();
    endtask

    task automatic test_reserved();
        int writes = 0;
        logic [4:0]  last_addr = wb_addr;
        logic [15:0] last_data = wb_data;
        drive(4'd13, 5'd11, 16'h5555, 16'hAAAA);
        total++; if (in_ready !== 1'b1) $display("FAIL rsv_ready in_ready=%b want 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (wb_en !== 1'b0 || busy !== 1'b0) $display("FAIL rsv_no_write wb_en=%b busy=%b want 0/0", wb_en, busy); else passed++;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom);
            op = 4'($urandom);
            step();
            if (wb_en !== 1'b0) writes++;
        end
        total++; if (writes != 0) $display("FAIL idle_no_write writes=%0d want 0", writes); else passed++;
        total++; if (wb_addr !== last_addr || wb_data !== last_data)
            $display("FAIL idle_hold addr=%0d data=%h want %0d/%h", wb_addr, wb_data, last_addr, last_data);
        else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        int mul_seen = 0;
        for (int n = 0; n < 300; n++) begin
            int unsigned o = $urandom_range(0, 15);
            logic [4:0]  r = 5'($urandom);
            logic [15:0] x = 16'($urandom);
            logic [15:0] y = 16'($urandom);
            logic [15:0] exp_d = ref_result(o, x, y);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
                if (wb_en !== 1'b0) begin
                    errs++;
                    $display("FAIL rnd_idle n=%0d wb_en=%b want 0", n, wb_en);
                end
            end
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL rnd_ready n=%0d in_ready=%b want 1", n, in_ready);
            end
            drive(4'(o), r, x, y);
            step();
            if (o == 10) begin
                int cyc = 0;
                mul_seen++;
                drive(4'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
                while (wb_en !== 1'b1 && cyc < 40) begin
                    step();
                    cyc++;
                end
                if (cyc != 16 || wb_addr !== r || wb_data !== exp_d) begin
                    errs++;
                    $display("FAIL rnd_mul n=%0d a=%h b=%h latency=%0d addr=%0d data=%h want 16/%0d/%h", n, x, y, cyc, wb_addr, wb_data, r, exp_d);
                end
            end else if (o <= 11) begin
                if (wb_en !== 1'b1 || wb_addr !== r || wb_data !== exp_d) begin
                    errs++;
                    $display("FAIL rnd_op n=%0d op=%0d a=%h b=%h wb_en=%b addr=%0d data=%h want 1/%0d/%h", n, o, x, y, wb_en, wb_addr, wb_data, r, exp_d);
                end
            end else begin
                if (wb_en !== 1'b0) begin
                    errs++;
                    $display("FAIL rnd_reserved n=%0d op=%0d wb_en=%b want 0", n, o, wb_en);
                end
            end
        end
        in_valid = 1'b0;
        step();
        total++; if (errs != 0) $display("FAIL random errors=%0d want 0", errs); else passed++;
        total++; if (mul_seen == 0) $display("FAIL random_mul_coverage mul_count=%0d want >0", mul_seen); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_mul_reset();
        test_reserved();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
